// File: rtl/alu_operand_stage_pkg.sv
// Shared constants and ALU opcode encoding for the operand issue stage.
// The stage treats opcodes as opaque and passes them through unchanged.
package alu_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int RIDX = 5;
  localparam int CNTW = 32;

  // bit 3 selects the compare variant of the base operation
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_SRA  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_bypass.sv
// Resolves one source operand: x0, then EX result, then WB data, then the
// register file. A load in EX never forwards since its data is not ready.
module operand_bypass #(
  parameter int XLEN = alu_operand_stage_pkg::XLEN,
  parameter int RIDX = alu_operand_stage_pkg::RIDX
) (
  input  logic [RIDX-1:0] idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RIDX-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_res,
  input  logic            wb_valid,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = rf_data;
    if (idx == '0)
      value = '0;
    else if (ex_valid && !ex_is_load && (ex_rd == idx))
      value = ex_res;
    else if (wb_valid && (wb_rd == idx))
      value = wb_data;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the ALU: reads and bypasses operands, holds off on
// load-use hazards and presents registered operands over valid/ready.
module alu_operand_stage #(
  parameter int XLEN = alu_operand_stage_pkg::XLEN,
  parameter int RIDX = alu_operand_stage_pkg::RIDX,
  parameter int CNTW = alu_operand_stage_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [3:0]      dec_op,
  input  logic [RIDX-1:0] dec_rs1,
  input  logic [RIDX-1:0] dec_rs2,
  input  logic [RIDX-1:0] dec_rd,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  output logic [RIDX-1:0] rf_raddr1,
  output logic [RIDX-1:0] rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [RIDX-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_res,
  input  logic            wb_valid,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [RIDX-1:0] alu_rd,
  output logic [CNTW-1:0] stall_cnt
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both
  // high at the rising edge; valid never depends on ready, and held payload is
  // stable while valid && !ready.
  logic            hazard;
  logic            space;
  logic            accept;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  assign hazard = dec_valid && ex_valid && ex_is_load && (ex_rd != '0) &&
                  ((ex_rd == dec_rs1) || (!dec_use_imm && (ex_rd == dec_rs2)));
  assign space     = !alu_valid || alu_ready;
  assign dec_ready = space && !hazard && !flush;
  assign accept    = dec_valid && dec_ready;

  operand_bypass #(.XLEN(XLEN), .RIDX(RIDX)) u_bypass1 (
    .idx        (dec_rs1),
    .rf_data    (rf_rdata1),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_res     (ex_res),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .value      (fwd1)
  );

  operand_bypass #(.XLEN(XLEN), .RIDX(RIDX)) u_bypass2 (
    .idx        (dec_rs2),
    .rf_data    (rf_rdata2),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .ex_res     (ex_res),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .value      (fwd2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        alu_valid <= 1'b0;
      end else if (accept) begin
        alu_valid <= 1'b1;
        alu_a     <= fwd1;
        alu_b     <= dec_use_imm ? dec_imm : fwd2;
        alu_op    <= dec_op;
        alu_rd    <= dec_rd;
      end else if (alu_ready) begin
        alu_valid <= 1'b0;
      end
      // a hazard behind a stuck output is backpressure, not a stall
      if (hazard && space && !flush && (stall_cnt != {CNTW{1'b1}}))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a transaction
// model; a narrow-counter instance exercises stall counter saturation.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  localparam int W     = 4 + RIDX + 2 * XLEN;
  localparam int CNTWS = 3;

  logic            clk = 1'b0;
  logic            rst, flush, dec_valid, dec_use_imm;
  logic [3:0]      dec_op;
  logic [RIDX-1:0] dec_rs1, dec_rs2, dec_rd, ex_rd, wb_rd;
  logic [XLEN-1:0] dec_imm, ex_res, wb_data, rf_rdata1, rf_rdata2;
  logic            ex_valid, ex_is_load, wb_valid, alu_ready;
  logic            dec_ready, alu_valid;
  logic [RIDX-1:0] rf_raddr1, rf_raddr2, alu_rd;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_op;
  logic [CNTW-1:0] stall_cnt;

  logic             dec_ready_s, alu_valid_s;
  logic [RIDX-1:0]  rf_raddr1_s, rf_raddr2_s, alu_rd_s;
  logic [XLEN-1:0]  alu_a_s, alu_b_s;
  logic [3:0]       alu_op_s;
  logic [CNTWS-1:0] stall_cnt_s;

  logic [XLEN-1:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  longint unsigned m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_res(ex_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_rd(alu_rd),
    .stall_cnt(stall_cnt)
  );

  alu_operand_stage #(.CNTW(CNTWS)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready_s), .dec_op(dec_op),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
    .rf_raddr1(rf_raddr1_s), .rf_raddr2(rf_raddr2_s),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_res(ex_res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_valid(alu_valid_s), .alu_ready(alu_ready),
    .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_op(alu_op_s), .alu_rd(alu_rd_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Operand value as the pipeline should see it, straight from the bypass rules.
  function automatic logic [XLEN-1:0] ref_operand(input logic [RIDX-1:0] idx);
    if (idx == 0) return '0;
    if (ex_valid && !ex_is_load && ex_rd == idx) return ex_res;
    if (wb_valid && wb_rd == idx) return wb_data;
    return rf_mem[idx];
  endfunction

  function automatic longint unsigned sat_inc(input longint unsigned v, input int bits);
    longint unsigned max_v = (64'd1 << bits) - 1;
    return (v == max_v) ? v : v + 1;
  endfunction

  // One clock: check combinational and held outputs before the edge, then
  // advance the model and check the counters just after it.
  task automatic cycle();
    bit hz, space, rdy, acc;
    logic [W-1:0] e, h;
    @(negedge clk);
    hz = dec_valid && ex_valid && ex_is_load && ex_rd != 0 &&
         (ex_rd == dec_rs1 || (!dec_use_imm && ex_rd == dec_rs2));
    space = (exp_q.size() == 0) || alu_ready;
    rdy = space && !hz && !flush;
    acc = dec_valid && rdy;
    e = {dec_op, dec_rd, ref_operand(dec_rs1), dec_use_imm ? dec_imm : ref_operand(dec_rs2)};
    if (!rst) begin
      check("dec_ready", dec_ready, rdy);
      check("rf_raddr1", rf_raddr1, dec_rs1);
      check("rf_raddr2", rf_raddr2, dec_rs2);
      check("alu_valid", alu_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        check("alu_op", alu_op, h[W-1 -: 4]);
        check("alu_rd", alu_rd, h[2*XLEN +: RIDX]);
        check("alu_a", alu_a, h[XLEN +: XLEN]);
        check("alu_b", alu_b, h[0 +: XLEN]);
      end
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_cnt_s = 0;
    end else begin
      if (hz && space && !flush) begin
        m_cnt = sat_inc(m_cnt, CNTW);
        m_cnt_s = sat_inc(m_cnt_s, CNTWS);
      end
      if (flush) exp_q.delete();
      else if (acc) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(e);
      end else if (alu_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    end
    #1;
    check("stall_cnt", stall_cnt, m_cnt);
    check("stall_cnt_s", stall_cnt_s, m_cnt_s);
  endtask

  task automatic idle_inputs();
    flush = 0; dec_valid = 0; dec_op = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    dec_imm = 0; dec_use_imm = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0;
    ex_res = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; alu_ready = 1;
  endtask

  task automatic issue(input logic [RIDX-1:0] rs1, input logic [RIDX-1:0] rs2,
                       input logic [RIDX-1:0] rd, input logic [3:0] op);
    dec_valid = 1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_op = op;
  endtask

  initial begin
    longint unsigned c0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    idle_inputs();
    rst = 1;
    dec_valid = 1;
    cycle();
    cycle();
    check("rst_alu_valid", alu_valid, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_rd", alu_rd, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    rst = 0;
    idle_inputs();

    // plain issue, then immediate operand
    rf_mem[3] = 32'd5; rf_mem[4] = 32'd7;
    issue(3, 4, 9, 4'd1);
    cycle();
    check("plain_valid", alu_valid, 1);
    check("plain_a", alu_a, 32'd5);
    check("plain_b", alu_b, 32'd7);
    check("plain_op", alu_op, 4'd1);
    check("plain_rd", alu_rd, 9);
    dec_use_imm = 1; dec_imm = 32'hFFFF_FFF0;
    cycle();
    check("imm_b", alu_b, 32'hFFFF_FFF0);
    dec_use_imm = 0;

    // forwarding priority
    rf_mem[6] = 32'h33;
    issue(6, 4, 10, ALU_ADD);
    ex_valid = 1; ex_rd = 6; ex_res = 32'h11;
    wb_valid = 1; wb_rd = 6; wb_data = 32'h22;
    cycle();
    check("fwd_ex", alu_a, 32'h11);
    ex_valid = 0;
    cycle();
    check("fwd_wb", alu_a, 32'h22);
    ex_valid = 1; ex_rd = 0; dec_rs1 = 0; wb_rd = 0;
    cycle();
    check("fwd_x0", alu_a, 0);
    idle_inputs();

    // load-use stall on rs2, then immediate form clears it
    issue(1, 2, 11, ALU_XOR);
    ex_valid = 1; ex_is_load = 1; ex_rd = 2;
    c0 = m_cnt;
    repeat (3) cycle();
    check("stall_plus3", stall_cnt, c0 + 3);
    dec_use_imm = 1;
    cycle();
    check("no_stall_imm", stall_cnt, c0 + 3);
    dec_use_imm = 0;
    repeat (10) cycle();
    check("stall_sat_small", stall_cnt_s, 7);
    idle_inputs();

    // backpressure: hold for three cycles, then drain without loss
    issue(3, 4, 12, ALU_OR);
    cycle();
    alu_ready = 0;
    issue(4, 3, 13, ALU_SLL);
    repeat (3) cycle();
    check("bp_hold_rd", alu_rd, 12);
    alu_ready = 1;
    cycle();
    dec_valid = 0;
    check("bp_next_rd", alu_rd, 13);
    cycle();

    // flush kills the held output and refuses the concurrent instruction
    issue(3, 4, 14, ALU_AND);
    alu_ready = 0;
    cycle();
    flush = 1;
    issue(4, 4, 15, ALU_SUB);
    cycle();
    check("flush_valid", alu_valid, 0);
    idle_inputs();
    cycle();

    // randomized traffic with narrow indices to provoke collisions
    for (int i = 0; i < 500; i++) begin
      rst = (i == 250);
      flush = ($urandom_range(0, 15) == 0);
      dec_valid = ($urandom_range(0, 3) != 0);
      dec_op = 4'($urandom_range(0, 15));
      dec_rs1 = RIDX'($urandom_range(0, 7));
      dec_rs2 = RIDX'($urandom_range(0, 7));
      dec_rd = RIDX'($urandom_range(0, 31));
      dec_imm = $urandom;
      dec_use_imm = ($urandom_range(0, 3) == 0);
      ex_valid = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_rd = RIDX'($urandom_range(0, 7));
      ex_res = $urandom;
      wb_valid = $urandom_range(0, 1);
      wb_rd = RIDX'($urandom_range(0, 7));
      wb_data = $urandom;
      alu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) rf_mem[$urandom_range(1, 7)] = $urandom;
      cycle();
    end
    rst = 0;
    idle_inputs();
    repeat (3) cycle();
    check("drained", alu_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 32-bit ALU (4-bit op: add/sub/sltu-style compare, and/or/xor, srl/sra/sll).
- Accepts decoded instructions over a valid/ready handshake, reads the register file, and resolves operands with bypass from the EX and WB stages.
- Detects load-use hazards and presents registered operands (a, b, op, rd) to the ALU over a valid/ready handshake.
- Keeps a saturating stall-cycle counter.

Parameters:
- XLEN, 32, operand/data width.
- RIDX, 5, register index width; register 0 reads as zero.
- CNTW, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the held output and drop the current input this cycle.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  stage accepts instruction this cycle.
- dec_op  in  4  ALU opcode, passed through.
- dec_rs1  in  RIDX  source 1 index.
- dec_rs2  in  RIDX  source 2 index.
- dec_rd  in  RIDX  destination index.
- dec_imm  in  XLEN  immediate.
- dec_use_imm  in  1  b = imm; rs2 not used.
- rf_raddr1  out  RIDX  combinational, = dec_rs1.
- rf_raddr2  out  RIDX  combinational, = dec_rs2.
- rf_rdata1  in  XLEN  register file read data (same cycle).
- rf_rdata2  in  XLEN  register file read data (same cycle).
- ex_valid  in  1  EX stage holds an instruction.
- ex_is_load  in  1  EX result not yet available.
- ex_rd  in  RIDX  EX destination.
- ex_res  in  XLEN  EX result.
- wb_valid  in  1  WB writing this cycle.
- wb_rd  in  RIDX  WB destination.
- wb_data  in  XLEN  WB data.
- alu_valid  out  1  operands valid.
- alu_ready  in  1  ALU/EX consumes operands.
- alu_a  out  XLEN  operand a.
- alu_b  out  XLEN  operand b.
- alu_op  out  4  opcode.
- alu_rd  out  RIDX  destination tag.
- stall_cnt  out  CNTW  saturating count of hazard-stall cycles.

Behaviour:
- Reset: alu_valid=0; alu_a, alu_b, alu_op, alu_rd = 0; stall_cnt=0. Reset wins over every other event; anything in flight is discarded.
- Forwarding, per source: if idx==0 the value is 0. Else if ex_valid && !ex_is_load && ex_rd==idx, use ex_res. Else if wb_valid && wb_rd==idx, use wb_data. Else use rf_rdata. EX has priority over WB.
- hazard = dec_valid && ex_valid && ex_is_load && ex_rd!=0 && (ex_rd==dec_rs1 || (!dec_use_imm && ex_rd==dec_rs2)).
- space = !alu_valid || alu_ready.
- dec_ready = space && !hazard && !flush (combinational).
- accept = dec_valid && dec_ready. On accept, next cycle: alu_valid=1; alu_a = fwd(rs1); alu_b = dec_use_imm ? dec_imm : fwd(rs2); alu_op, alu_rd latched.
- Latency: 1 cycle from accept to alu_valid.
- Back-to-back accepts are allowed when alu_ready=1: throughput 1 per cycle.
- alu_valid && !alu_ready: all alu_* outputs hold stable, no accept.
- alu_valid && alu_ready && !accept: alu_valid goes 0 next cycle.
- flush: alu_valid goes 0 next cycle, no accept, stall_cnt unchanged. Data registers may keep stale values.
- stall_cnt increments each cycle where hazard && space && !flush, and saturates at all-ones.
- Hazard with a full, non-consumed output counts as backpressure, not a stall.
- Holding is a pure register hold; operands are never re-resolved while held.

Decomposition:
- Shared package (team cpu pkg): XLEN/RIDX constants and the ALU opcode enum (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SRL=5, SRA=6, SLL=7, bit3 = compare variant). This block uses the enum as an opaque passthrough.
- One natural sub-module: operand_bypass, purely combinational (idx, rf data, ex/wb taps -> value), instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles with dec_valid=1 -> alu_valid=0, all outputs 0, stall_cnt=0.
- Plain issue: rf x3=5, x4=7, op=1, rd=9, use_imm=0 -> next cycle alu_valid=1, a=5, b=7, op=1, rd=9. dec_use_imm=1, imm=0xFFFF_FFF0 -> b=0xFFFF_FFF0.
- Forward priority: rs1=6, ex_rd=6 ex_res=0x11, wb_rd=6 wb_data=0x22, rf=0x33 -> a=0x11. With ex_valid=0 -> a=0x22. With rs1=0 and ex_rd=0 -> a=0.
- Load-use: ex_is_load=1, ex_rd=2, dec_rs2=2 -> dec_ready=0, stall_cnt +1 per cycle. With use_imm=1 instead -> no stall.
- Backpressure: alu_ready=0 for 3 cycles with a new dec_valid -> outputs hold, dec_ready=0. alu_ready=1 -> next instruction issues the following cycle, none lost or duplicated.
- Flush: alu_valid=1, flush=1 -> alu_valid=0 next cycle, concurrent dec_valid not accepted. stall_cnt preset near max saturates at 0xFFFF_FFFF.
